// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, FSM state encoding and flag bit positions for alu_seq_hs.
`default_nettype none

package alu_seq_pkg;

  localparam logic [3:0] OP_XFER_INC  = 4'd0;
  localparam logic [3:0] OP_ADD       = 4'd1;
  localparam logic [3:0] OP_SUB       = 4'd2;
  localparam logic [3:0] OP_DEC_XFERB = 4'd3;
  localparam logic [3:0] OP_AND       = 4'd4;
  localparam logic [3:0] OP_OR_XOR    = 4'd5;
  localparam logic [3:0] OP_NOT       = 4'd6;
  localparam logic [3:0] OP_SHIFT1    = 4'd7;
  localparam logic [3:0] OP_ZERO      = 4'd8;
  localparam logic [3:0] OP_SHL_N     = 4'd9;
  localparam logic [3:0] OP_SHR_N     = 4'd10;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_comb_core.sv
// alu_comb_core: combinational ALU for op codes 0-8; codes 0-3 share one WIDTH+1 bit adder.
`default_nettype none

module alu_comb_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
  input  logic [3:0]       select,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             add_ovf;

  // Each arithmetic op is expressed as x + y + cin so carry and overflow come from one place.
  always_comb begin
    add_x   = op_a;
    add_y   = '0;
    add_cin = 1'b0;
    case (select)
      OP_XFER_INC: add_cin = c_in;
      OP_ADD: begin
        add_y   = op_b;
        add_cin = c_in;
      end
      OP_SUB: begin
        add_y   = ~op_b;
        add_cin = c_in;
      end
      OP_DEC_XFERB: begin
        if (c_in) begin
          add_x = '0;
          add_y = op_b;
        end else begin
          add_y = '1;
        end
      end
      default: ;
    endcase
  end

  assign sum     = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (select)
      OP_XFER_INC, OP_ADD, OP_SUB, OP_DEC_XFERB: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = add_ovf;
      end
      OP_AND:    result = op_a & op_b;
      OP_OR_XOR: result = c_in ? (op_a ^ op_b) : (op_a | op_b);
      OP_NOT:    result = ~op_a;
      OP_SHIFT1: begin
        if (c_in) begin
          result = {1'b0, op_a[WIDTH-1:1]};
          carry  = op_a[0];
        end else begin
          result = {op_a[WIDTH-2:0], 1'b0};
          carry  = op_a[WIDTH-1];
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq_hs.sv
// alu_seq_hs: registered ALU with valid/ready handshake, flags, accumulator operand
// and a one-bit-per-cycle multi-cycle shift; one op in flight at a time.
`default_nettype none

module alu_seq_hs
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [3:0]       select,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags,
  output logic             illegal
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       flags_q, flags_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] op_a;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic             core_ovf;
  logic [WIDTH-1:0] shifted;
  logic             shift_out;
  logic             is_shift_n;
  logic             is_illegal;

  function automatic logic [3:0] pack_flags(input logic ovf, input logic [WIDTH-1:0] r,
                                            input logic carry);
    logic [3:0] f;
    f             = '0;
    f[FLAG_OVF]   = ovf;
    f[FLAG_NEG]   = r[WIDTH-1];
    f[FLAG_ZERO]  = (r == '0);
    f[FLAG_CARRY] = carry;
    return f;
  endfunction

  assign op_a       = acc_sel ? acc_q : a;
  assign shamt      = b[SHW-1:0];
  assign is_shift_n = (select == OP_SHL_N) || (select == OP_SHR_N);
  assign is_illegal = (select > OP_SHR_N);

  alu_comb_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_a   (op_a),
    .op_b   (b),
    .c_in   (c_in),
    .select (select),
    .result (core_res),
    .carry  (core_carry),
    .ovf    (core_ovf)
  );

  // dir_q=1 is a logical right shift; the bit leaving the register becomes carry.
  assign shifted   = dir_q ? {1'b0, work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};
  assign shift_out = dir_q ? work_q[0] : work_q[WIDTH-1];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign y         = y_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    acc_d     = acc_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_illegal) begin
            state_d   = HOLD;
            y_d       = '0;
            flags_d   = '0;
            illegal_d = 1'b1;
          end else if (is_shift_n && (shamt == '0)) begin
            state_d   = HOLD;
            y_d       = op_a;
            flags_d   = pack_flags(1'b0, op_a, 1'b0);
            illegal_d = 1'b0;
            acc_d     = op_a;
          end else if (is_shift_n) begin
            state_d = SHIFT;
            work_d  = op_a;
            cnt_d   = shamt;
            dir_d   = (select == OP_SHR_N);
          end else begin
            state_d   = HOLD;
            y_d       = core_res;
            flags_d   = pack_flags(core_ovf, core_res, core_carry);
            illegal_d = 1'b0;
            acc_d     = core_res;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          state_d   = HOLD;
          y_d       = shifted;
          flags_d   = pack_flags(1'b0, shifted, shift_out);
          illegal_d = 1'b0;
          acc_d     = shifted;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      y_q       <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
      acc_q     <= acc_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_hs.sv
// tb_alu_seq_hs: directed vectors with hand-computed results for alu_seq_hs (WIDTH=8).
`default_nettype none

module tb_alu_seq_hs;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic [3:0] select;
  logic       acc_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [3:0] flags;
  logic       illegal;

  int vectors     = 0;
  int miscompares = 0;
  int lat;

  alu_seq_hs #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .select    (select),
    .acc_sel   (acc_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one op for one edge, then count cycles until out_valid (lat=1 means next cycle).
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [3:0] ts, input logic tacc, output int tlat);
    @(negedge clk);
    a = ta; b = tb; c_in = tc; select = ts; acc_sel = tacc; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tlat = 1;
    while (!out_valid && tlat < 40) begin
      @(posedge clk);
      #1;
      tlat++;
    end
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; select = '0;
    acc_sel = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset y", y, 8'h00);
    chk("reset flags", flags, 4'h0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset illegal", illegal, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset in_ready", in_ready, 1'b1);

    // Add: 0xAA + 0x55
    issue(8'hAA, 8'h55, 1'b0, 4'd1, 1'b0, lat);
    chk("add latency", lat, 1);
    chk("add y", y, 8'hFF);
    chk("add flags", flags, 4'b0100);
    retire();

    // Subtract with signed overflow
    issue(8'hAA, 8'h55, 1'b1, 4'd2, 1'b0, lat);
    chk("sub y", y, 8'h55);
    chk("sub flags", flags, 4'b1001);
    retire();

    // Increment wrap
    issue(8'hFF, 8'h00, 1'b1, 4'd0, 1'b0, lat);
    chk("inc wrap y", y, 8'h00);
    chk("inc wrap flags", flags, 4'b0011);
    retire();

    // Decrement wrap
    issue(8'h00, 8'h00, 1'b0, 4'd3, 1'b0, lat);
    chk("dec wrap y", y, 8'hFF);
    chk("dec wrap flags", flags, 4'b0100);
    retire();

    // Transfer b
    issue(8'h12, 8'h9C, 1'b1, 4'd3, 1'b0, lat);
    chk("xfer b y", y, 8'h9C);
    retire();

    // Single-bit shift left with carry out
    issue(8'h81, 8'h00, 1'b0, 4'd7, 1'b0, lat);
    chk("shl1 y", y, 8'h02);
    chk("shl1 flags", flags, 4'b0001);
    retire();

    // Xor
    issue(8'hF0, 8'h3C, 1'b1, 4'd5, 1'b0, lat);
    chk("xor y", y, 8'hCC);
    retire();

    // Multi-cycle shift left by 3
    @(negedge clk);
    a = 8'h81; b = 8'h03; c_in = 1'b0; select = 4'd9; acc_sel = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("shl3 in_ready busy", in_ready, 1'b0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("shl3 latency", lat, 4);
    chk("shl3 y", y, 8'h08);
    chk("shl3 flags", flags, 4'b0000);
    retire();

    // Shift by zero completes in one cycle
    issue(8'h81, 8'h00, 1'b0, 4'd9, 1'b0, lat);
    chk("shl0 latency", lat, 1);
    chk("shl0 y", y, 8'h81);
    chk("shl0 flags", flags, 4'b0100);
    retire();

    // Multi-cycle shift right by 1, carry from bit 0
    issue(8'hF1, 8'h01, 1'b0, 4'd10, 1'b0, lat);
    chk("shr1n latency", lat, 2);
    chk("shr1n y", y, 8'h78);
    chk("shr1n flags", flags, 4'b0001);
    retire();

    // Back-pressure: result must hold while out_ready is low
    issue(8'h3C, 8'h0F, 1'b0, 4'd4, 1'b0, lat);
    chk("and y", y, 8'h0C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 8'(i * 37 + 5); select = 4'd0; c_in = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("hold y", y, 8'h0C);
      chk("hold flags", flags, 4'b0000);
      chk("hold in_ready", in_ready, 1'b0);
      chk("hold out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    retire();
    chk("post hold out_valid", out_valid, 1'b0);
    chk("post hold in_ready", in_ready, 1'b1);
    issue(8'h01, 8'h00, 1'b1, 4'd0, 1'b0, lat);
    chk("post hold latency", lat, 1);
    chk("post hold y", y, 8'h02);
    retire();

    // Accumulator sequence
    issue(8'h10, 8'h00, 1'b0, 4'd0, 1'b0, lat);
    chk("acc load y", y, 8'h10);
    retire();
    issue(8'h00, 8'h05, 1'b0, 4'd1, 1'b1, lat);
    chk("acc add y", y, 8'h15);
    retire();
    issue(8'h77, 8'h05, 1'b0, 4'd12, 1'b0, lat);
    chk("illegal flag", illegal, 1'b1);
    chk("illegal y", y, 8'h00);
    chk("illegal flags", flags, 4'b0000);
    retire();
    issue(8'h00, 8'h00, 1'b0, 4'd0, 1'b1, lat);
    chk("acc kept y", y, 8'h15);
    chk("acc kept illegal", illegal, 1'b0);
    retire();
    issue(8'h55, 8'h00, 1'b0, 4'd8, 1'b1, lat);
    chk("clear y", y, 8'h00);
    retire();
    issue(8'h66, 8'h00, 1'b0, 4'd0, 1'b1, lat);
    chk("acc cleared y", y, 8'h00);
    chk("acc cleared flags", flags, 4'b0010);
    retire();

    // Reset in the middle of a long shift
    issue(8'h77, 8'h00, 1'b0, 4'd0, 1'b0, lat);
    chk("pre reset y", y, 8'h77);
    retire();
    @(negedge clk);
    a = 8'hF0; b = 8'h06; c_in = 1'b0; select = 4'd10; acc_sel = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid reset out_valid", out_valid, 1'b0);
    chk("mid reset y", y, 8'h00);
    chk("mid reset flags", flags, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after reset in_ready", in_ready, 1'b1);
    issue(8'h99, 8'h00, 1'b0, 4'd0, 1'b1, lat);
    chk("after reset acc", y, 8'h00);
    retire();
    issue(8'hF0, 8'h3C, 1'b0, 4'd4, 1'b0, lat);
    chk("after reset and latency", lat, 1);
    chk("after reset and y", y, 8'h30);
    chk("after reset and flags", flags, 4'b0000);
    retire();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq_hs.md
Name: alu_seq_hs

Overview:
Next-generation ALU. It is parametrised in width and registered. It adds a valid/ready handshake on input and output, status flags, an accumulator that can stand in as operand A, and a multi-cycle shift-by-N op. It keeps the existing select/c_in op map for codes 0–8, so existing directed vectors port directly. It sits between the operand sequencer and the result writeback stage.

Parameters:
- WIDTH, 8: operand/result width. Must be a power of two, ≥4.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept an op
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount for ops 9/10
- c_in  in  1  carry-in / op modifier
- select  in  4  op code
- acc_sel  in  1  1 = accumulator replaces a as operand A
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- y  out  WIDTH  result
- flags  out  4  {ovf, neg, zero, carry}
- illegal  out  1  the held result came from an unused op code

Behaviour:
- Reset (async, any state): state=IDLE; y, flags, illegal, acc, shift counter = 0; out_valid=0; in_ready=1 after release. An in-flight op is discarded.
- FSM states: IDLE, SHIFT, HOLD.
  - in_ready = (state==IDLE). No overlap: one op in flight.
  - Accept = in_valid && in_ready at a rising edge. A and B are captured at that edge.
  - IDLE to HOLD: at accept for single-cycle ops, and for op 9/10 with amount 0. Result goes into y/flags at the same edge, so out_valid rises 1 cycle after accept.
  - IDLE to SHIFT: at accept for op 9/10 with amount N>0. A is loaded into the work register and count=N.
  - In SHIFT, each edge shifts 1 bit and decrements count. When count==1 the edge moves to HOLD. Total latency is N+1 cycles; in_ready stays low throughout.
  - HOLD: y, flags and illegal stay stable while out_ready=0. On out_valid && out_ready go to IDLE; the new op can be accepted on the next cycle.
- Op map, with A = acc_sel ? acc : a:
  - sel 0: c_in=0 gives A; c_in=1 gives A+1.
  - sel 1: A+b+c_in.
  - sel 2: A+~b+c_in (c_in=1 is the subtract).
  - sel 3: c_in=0 gives A-1; c_in=1 gives b.
  - sel 4: A&b.
  - sel 5: c_in=0 gives A|b; c_in=1 gives A^b.
  - sel 6: ~A.
  - sel 7: c_in=0 gives A<<1; c_in=1 gives A>>1 (logical, 1 cycle).
  - sel 8: 0.
  - sel 9: A<<N (multi-cycle).
  - sel 10: A>>N (multi-cycle, logical).
  - sel 11–15: result 0, illegal=1, flags=0.
- Arithmetic rules:
  - All arithmetic is computed at WIDTH+1 bits. carry = bit WIDTH; for sel 2 this means carry=1 indicates no borrow.
  - ovf = signed overflow for sel 0–3; 0 otherwise.
  - For single shifts and ops 9/10, carry = last bit shifted out (0 if N=0). Logic ops give carry=0.
  - zero = (y==0); neg = y[WIDTH-1].
  - Wrap-around: A+1 on all-ones gives 0, carry=1; A-1 on 0 gives all-ones, carry=0.
- Accumulator: acc is loaded with the result on the edge entering HOLD, for every legal op. It is unchanged on illegal codes. sel 8 with any acc_sel clears acc.
- in_valid asserted outside IDLE is ignored (no capture). Inputs may change freely while in_ready=0.

Decomposition:
- Package alu_seq_pkg: op-code localparams (OP_XFER_INC … OP_SHR_N), state enum {IDLE, SHIFT, HOLD}, flag bit indices.
- One sub-module, alu_comb_core: combinational WIDTH-parametrised ALU for sel 0–8 returning {carry, ovf, result}. The top holds the FSM, shift datapath, accumulator and handshake.

Test Plan:
1. WIDTH=8, a=0xAA, b=0x55, sel=1, c_in=0 → y=0xFF, carry=0, neg=1, zero=0, ovf=0; out_valid 1 cycle after accept.
2. a=0xAA, b=0x55, sel=2, c_in=1 → y=0x55, carry=1, ovf=1, neg=0. Then a=0xFF, sel=0, c_in=1 → y=0x00, carry=1, zero=1.
3. a=0x81, b=0x03, sel=9 → in_ready low 3 cycles; out_valid in cycle 4 after accept; y=0x08, carry=0. Repeat with b=0 → 1-cycle latency, y=0x81, carry=0.
4. Hold out_ready=0 for 5 cycles with in_valid=1 and changing a → y/flags stable, in_ready=0, no second capture. out_ready=1 → IDLE, next op accepted the following cycle.
5. Accumulator sequence:
   - a=0x10, sel=0 → acc=0x10.
   - acc_sel=1, b=0x05, sel=1 → y=0x15.
   - sel=12 → illegal=1, y=0, acc remains 0x15.
   - sel=8 → acc=0.
6. Assert rst mid-SHIFT (a=0xF0, b=6, sel=10, after 2 cycles) → out_valid=0, y=0, acc=0 immediately; after release, in_ready=1 and a fresh sel=4 op (0xF0&0x3C) gives 0x30.
